frame_seq_ctrl: RTL and testbench

//   Frame sequencer between uart_rx and sobel_algorithm. Parses a byte-command protocol from the UART
//   (sync byte, then a command). Gates exactly IMG_W*IMG_H pixel bytes per frame into the Sobel datapath.

---
 rtl/edge_det_pkg.sv | 15 +
 rtl/activity_timer.sv | 31 +++
 rtl/frame_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_frame_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared encodings for the frame sequencer: FSM states and UART command codes.
package edge_det_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    THR    = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_SET_THR = 8'h01;
  localparam logic [7:0] CMD_FRAME   = 8'h02;

endpackage

// File: rtl/activity_timer.sv
// Idle-cycle watchdog: counts cycles while run is high, restarts on clear.
// Latency: expire rises TIMEOUT_CYC cycles after the last clear, stays high while run.
// Backpressure: none; pure counter, expire is held until clear or run drops.
module activity_timer #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = run && (cnt == LIMIT);

endmodule

// File: rtl/frame_seq_ctrl.sv
// UART command parser and pixel gate in front of the Sobel datapath; optional watchdog FRAME_SEQ_WATCHDOG_EN.
// Latency: pix_valid/pix_data one cycle after rx_valid; frame_done one cycle after the final sobel_flag.
// Backpressure: none; bytes arriving while draining are dropped with an err pulse.
module frame_seq_ctrl
  import edge_det_pkg::*;
#(
  parameter int         IMG_W       = 100,
  parameter int         IMG_H       = 100,
  parameter logic [7:0] SYNC_BYTE   = 8'h55,
  parameter logic [7:0] THR_DEFAULT = 8'd128,
  parameter int         TIMEOUT_CYC = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       sobel_flag,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  output logic [7:0] threshold,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  localparam int CW = $clog2(IMG_W * IMG_H + 1);
  localparam logic [CW-1:0] LAST_IN = CW'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0] N_OUT   = CW'((IMG_W - 2) * (IMG_H - 2));

  state_t          state, state_nxt;
  logic [CW-1:0]   in_cnt, in_cnt_nxt;
  logic [CW-1:0]   out_cnt, out_cnt_nxt;
  logic [7:0]      thr_nxt, pix_data_nxt;
  logic            pix_valid_nxt, frame_done_nxt, err_nxt;
  logic            expire;

  assign busy = (state == STREAM) || (state == DRAIN);

  always_comb begin
    state_nxt      = state;
    in_cnt_nxt     = in_cnt;
    out_cnt_nxt    = out_cnt;
    thr_nxt        = threshold;
    pix_data_nxt   = pix_data;
    pix_valid_nxt  = 1'b0;
    frame_done_nxt = 1'b0;
    err_nxt        = 1'b0;

    // Output count saturates so a flag racing the last input byte cannot overshoot.
    if (busy && sobel_flag && out_cnt != N_OUT) begin
      out_cnt_nxt = out_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_nxt = CMD;
      end
      CMD: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_SET_THR: state_nxt = THR;
            CMD_FRAME: begin
              state_nxt   = STREAM;
              in_cnt_nxt  = '0;
              out_cnt_nxt = '0;
            end
            default: begin
              state_nxt = IDLE;
              err_nxt   = 1'b1;
            end
          endcase
        end
      end
      THR: begin
        if (rx_valid) begin
          thr_nxt   = rx_data;
          state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (rx_valid) begin
          pix_data_nxt  = rx_data;
          pix_valid_nxt = 1'b1;
          in_cnt_nxt    = in_cnt + 1'b1;
          if (in_cnt == LAST_IN) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_cnt_nxt == N_OUT) begin
          state_nxt      = IDLE;
          frame_done_nxt = 1'b1;
        end else if (rx_valid) begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A completing frame wins over a simultaneous timeout so the two pulses never overlap.
    if (expire && !frame_done_nxt) begin
      state_nxt     = IDLE;
      pix_valid_nxt = 1'b0;
      err_nxt       = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      pix_data   <= 8'd0;
      pix_valid  <= 1'b0;
      threshold  <= THR_DEFAULT;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_cnt     <= in_cnt_nxt;
      out_cnt    <= out_cnt_nxt;
      pix_data   <= pix_data_nxt;
      pix_valid  <= pix_valid_nxt;
      threshold  <= thr_nxt;
      frame_done <= frame_done_nxt;
      err        <= err_nxt;
    end
  end

`ifdef FRAME_SEQ_WATCHDOG_EN
  activity_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_activity_timer (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clear  (rx_valid | sobel_flag),
    .run    (busy),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl with a 4x4 image and a 100-cycle watchdog.
module tb_frame_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sobel_flag;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic [7:0] threshold;
  logic       busy;
  logic       frame_done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int pv_cnt  = 0;
  int fd_cnt  = 0;
  int er_cnt  = 0;

  frame_seq_ctrl #(
    .IMG_W       (4),
    .IMG_H       (4),
    .SYNC_BYTE   (8'h55),
    .THR_DEFAULT (8'd128),
    .TIMEOUT_CYC (100)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .sobel_flag (sobel_flag),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .threshold  (threshold),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (pix_valid)  pv_cnt++;
    if (frame_done) fd_cnt++;
    if (err)        er_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit flag, input bit chk_pix);
    @(posedge sys_clk);
    #1;
    rx_data    = b;
    rx_valid   = 1'b1;
    sobel_flag = flag;
    @(posedge sys_clk);
    #1;
    rx_valid   = 1'b0;
    sobel_flag = 1'b0;
    if (chk_pix) begin
      check("pix_valid", {31'd0, pix_valid}, 32'd1);
      check("pix_data", {24'd0, pix_data}, {24'd0, b});
    end
  endtask

  task automatic pulse_flag(input bit exp_fd);
    @(posedge sys_clk);
    #1;
    sobel_flag = 1'b1;
    @(posedge sys_clk);
    #1;
    sobel_flag = 1'b0;
    check("frame_done_timing", {31'd0, frame_done}, {31'd0, exp_fd});
  endtask

  function automatic logic [7:0] pix_val(input int i);
    logic [7:0] v;
    v = 8'h44 + 8'(i * 17);
    return v;
  endfunction

  task automatic do_reset();
    #3;
    sys_rst_n = 1'b0;
    idle(2);
    sys_rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    int pv0, fd0, er0, waited;
    sys_rst_n  = 1'b0;
    rx_data    = 8'd0;
    rx_valid   = 1'b0;
    sobel_flag = 1'b0;
    idle(3);
    check("rst_threshold", {24'd0, threshold}, 32'd128);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_pix_data", {24'd0, pix_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    sys_rst_n = 1'b1;
    idle(1);

    // 1. threshold set, preceded by a stray byte that IDLE must drop silently
    er0 = er_cnt;
    send(8'hA7, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    idle(1);
    check("thr_set", {24'd0, threshold}, 32'h3C);
    check("thr_busy", {31'd0, busy}, 32'd0);
    check("thr_no_err", er_cnt - er0, 0);

    // 2. full frame; pixel 1 equals the sync byte
    pv0 = pv_cnt; fd0 = fd_cnt;
    send(8'h55, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    check("frame_busy_stream", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) send(pix_val(i), 1'b0, 1'b1);
    idle(1);
    check("frame_pix_count", pv_cnt - pv0, 16);
    check("frame_busy_drain", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++) pulse_flag(k == 3);
    idle(1);
    check("frame_done_count", fd_cnt - fd0, 1);
    check("frame_idle_busy", {31'd0, busy}, 32'd0);

    // 3. bad command then recovery
    er0 = er_cnt;
    send(8'h55, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    idle(1);
    check("badcmd_err", er_cnt - er0, 1);
    check("badcmd_busy", {31'd0, busy}, 32'd0);
    send(8'h55, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    idle(1);
    check("badcmd_thr", {24'd0, threshold}, 32'h10);

    // 4. flag coincident with a pixel, then an overrun byte in DRAIN
    pv0 = pv_cnt; fd0 = fd_cnt;
    send(8'h55, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send(pix_val(15 - i), i == 5, 1'b1);
    er0 = er_cnt;
    send(8'hEE, 1'b0, 1'b0);
    idle(1);
    check("ovr_err", er_cnt - er0, 1);
    check("ovr_no_pix", pv_cnt - pv0, 16);
    check("ovr_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 3; k++) pulse_flag(k == 2);
    idle(1);
    check("ovr_frame_done", fd_cnt - fd0, 1);
    check("ovr_busy_end", {31'd0, busy}, 32'd0);

    // 5. reset in the middle of a frame
    fd0 = fd_cnt;
    send(8'h55, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(pix_val(i), 1'b0, 1'b1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_thr", {24'd0, threshold}, 32'd128);
    idle(2);
    sys_rst_n = 1'b1;
    idle(1);
    check("midrst_no_fd", fd_cnt - fd0, 0);
    send(8'h55, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) send(pix_val(i), 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) pulse_flag(1'b0);
    idle(1);
    check("refr_busy_15", {31'd0, busy}, 32'd1);
    check("refr_no_fd_15", fd_cnt - fd0, 0);
    send(pix_val(15), 1'b0, 1'b1);
    idle(2);
    check("refr_fd_16", fd_cnt - fd0, 1);
    check("refr_busy_end", {31'd0, busy}, 32'd0);

    // 6. stalled stream after 9 pixels
    fd0 = fd_cnt; er0 = er_cnt;
    send(8'h55, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) send(pix_val(i), 1'b0, 1'b1);
`ifdef FRAME_SEQ_WATCHDOG_EN
    waited = 0;
    while (er_cnt == er0 && waited < 200) begin
      idle(1);
      waited++;
    end
    check("wd_err", er_cnt - er0, 1);
    check("wd_timing", {31'd0, (waited >= 95 && waited <= 105)}, 32'd1);
    check("wd_busy", {31'd0, busy}, 32'd0);
    check("wd_no_fd", fd_cnt - fd0, 0);
`else
    waited = 0;
    idle(150);
    check("nowd_busy", {31'd0, busy}, 32'd1);
    check("nowd_no_err", er_cnt - er0, waited);
`endif
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
